// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//
// Deck-accounting dealer between the LFSR rank generator and the game FSMs.
// Requesters share the generator through a round-robin arbiter. Each grant
// delivers one rank that still has copies left in a shoe of DECKS decks.
// Samples of exhausted or out-of-range ranks are retried. After MAX_TRIES
// retries, a one-cycle upward scan picks the next available rank instead.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-low reset
//   rnd[3:0]    free-running rank from the LFSR (1..13 expected)
//   req[N-1:0]  level request per requester (bit 0 player, bit 1 dealer)
//   shuffle     one-cycle pulse: refill the shoe
//   gnt[N-1:0]  one-hot, one-cycle grant pulse
//   card_valid  one-cycle pulse coincident with gnt
//   card[3:0]   dealt rank, held until the next deal
//   cards_left  cards remaining in the shoe
//   deck_empty  high while cards_left == 0
//   busy        high in any state other than IDLE
// -----------------------------------------------------------------------------
module card_dealer #(
   parameter int N_REQ     = 2,
   parameter int DECKS     = 1,
   parameter int MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       rnd,
   input  logic [N_REQ-1:0] req,
   input  logic             shuffle,
   output logic [N_REQ-1:0] gnt,
   output logic             card_valid,
   output logic [3:0]       card,
   output logic [7:0]       cards_left,
   output logic             deck_empty,
   output logic             busy
);

   localparam int         PW       = (N_REQ > 2) ? 2 : 1;
   localparam logic [4:0] RANK_MAX = 5'(4 * DECKS);
   localparam logic [7:0] FULL     = 8'(52 * DECKS);
   localparam logic [3:0] TRY_LIM  = 4'(MAX_TRIES);

   typedef enum logic [1:0] {IDLE, DRAW, DELIVER, SHUFFLE} state_t;

   state_t          state, state_nx;
   logic [4:0]      dealt [13];   // copies dealt per rank, index = rank-1
   logic [12:0]     avail;        // rank still has copies in the shoe
   logic [PW-1:0]   ptr, winner, pick;
   logic            any_req;
   logic [3:0]      tries;
   logic            pend;
   logic            rnd_in, rnd_ok, accept, fallback;
   logic [3:0]      scan_base, scan_rank, take_rank;
   int              arb_best, scan_best;
   logic [N_REQ-1:0] onehot;

   always_comb begin
      for (int i = 0; i < 13; i++) avail[i] = (dealt[i] < RANK_MAX);
   end

   // Round-robin: the set request with the smallest distance from ptr wins.
   // NOTE: every variable written here gets a default first, so no path
   // through the block can leave a value held and infer a latch.
   always_comb begin
      any_req  = |req;
      pick     = ptr;
      arb_best = N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
         if (req[j] && ((j - int'(ptr) + N_REQ) % N_REQ) < arb_best) begin
            arb_best = (j - int'(ptr) + N_REQ) % N_REQ;
            pick     = PW'(j);
         end
      end
   end

   assign rnd_in = (rnd >= 4'd1) && (rnd <= 4'd13);
   assign rnd_ok = rnd_in && avail[rnd - 4'd1];

   // Fallback scan: first available rank at or above rnd, wrapping 13 -> 1.
   // The deal only starts with cards_left != 0, so some rank always matches.
   always_comb begin
      scan_base = rnd_in ? (rnd - 4'd1) : 4'd0;
      scan_rank = 4'd1;
      scan_best = 13;
      for (int j = 0; j < 13; j++) begin
         if (avail[j] && ((j - int'(scan_base) + 13) % 13) < scan_best) begin
            scan_best = (j - int'(scan_base) + 13) % 13;
            scan_rank = 4'(j + 1);
         end
      end
   end

   assign fallback  = (state == DRAW) && (tries == TRY_LIM);
   assign accept    = (state == DRAW) && (tries != TRY_LIM) && rnd_ok;
   assign take_rank = fallback ? scan_rank : rnd;
   assign onehot    = N_REQ'(1) << winner;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (pend || shuffle)                    state_nx = SHUFFLE;
            else if (any_req && cards_left != 8'd0) state_nx = DRAW;
         end
         DRAW:    if (accept || fallback) state_nx = DELIVER;
         DELIVER: state_nx = IDLE;
         SHUFFLE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign deck_empty = (cards_left == 8'd0);

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         ptr        <= '0;
         winner     <= '0;
         tries      <= '0;
         pend       <= 1'b0;
         card       <= '0;
         cards_left <= FULL;
         gnt        <= '0;
         card_valid <= 1'b0;
         // NOTE: the rank counters are architectural state (reset means a
         // full shoe), so this small array is cleared like any register.
         for (int i = 0; i < 13; i++) dealt[i] <= '0;
      end else begin
         state      <= state_nx;
         gnt        <= '0;
         card_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!(pend || shuffle) && any_req && cards_left != 8'd0)
                  winner <= pick;
            end
            DRAW: begin
               if (shuffle) pend <= 1'b1;
               if (accept || fallback) begin
                  card                      <= take_rank;
                  dealt[take_rank - 4'd1]   <= dealt[take_rank - 4'd1] + 5'd1;
                  cards_left                <= cards_left - 8'd1;
               end else begin
                  tries <= tries + 4'd1;
               end
            end
            DELIVER: begin
               if (shuffle) pend <= 1'b1;
               gnt        <= onehot;
               card_valid <= 1'b1;
               ptr        <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
               tries      <= '0;
            end
            SHUFFLE: begin
               for (int i = 0; i < 13; i++) dealt[i] <= '0;
               cards_left <= FULL;
               pend       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
//
// Directed sequence with randomized ranks. The reference model keeps
// per-rank remaining copies, the shoe size and the round-robin pointer, and
// derives each expected card and its delivery cycle from the dealing rules.
// -----------------------------------------------------------------------------
module tb_card_dealer;

   localparam int N     = 2;
   localparam int DECKS = 1;
   localparam int MT    = 8;
   localparam int FULL  = 52 * DECKS;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   rnd;
   logic [N-1:0] req;
   logic         shuffle;
   logic [N-1:0] gnt;
   logic         card_valid;
   logic [3:0]   card;
   logic [7:0]   cards_left;
   logic         deck_empty;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int rem   [16];   // model: copies left per rank (index = rank)
   int tally [16];   // observed cards per rank
   int left;
   int ptr_m;

   card_dealer #(.N_REQ(N), .DECKS(DECKS), .MAX_TRIES(MT)) dut (
      .clk        (clk),
      .rst        (rst),
      .rnd        (rnd),
      .req        (req),
      .shuffle    (shuffle),
      .gnt        (gnt),
      .card_valid (card_valid),
      .card       (card),
      .cards_left (cards_left),
      .deck_empty (deck_empty),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input logic [3:0] v);
      return (v >= 4'd1) && (v <= 4'd13);
   endfunction

   task automatic model_refill();
      for (int r = 0; r < 16; r++) rem[r] = (r >= 1 && r <= 13) ? 4 * DECKS : 0;
      left = FULL;
   endtask

   // One complete deal. Called at a negedge with the DUT in IDLE.
   task automatic do_deal(input logic [N-1:0] rq, input bit fixed, input int fval,
                          input bit shuf, output logic [3:0] got);
      logic [3:0] rv [MT+1];
      logic [3:0] exp_card, start, r;
      int         kd, w;
      w = -1;
      for (int i = 0; i < N; i++) begin
         int j;
         j = (ptr_m + i) % N;
         if (w < 0 && ((int'(rq) >> j) & 1) == 1) w = j;
      end
      for (int k = 0; k <= MT; k++)
         rv[k] = fixed ? 4'(fval) : 4'($urandom_range(0, 15));
      exp_card = 4'd0;
      kd       = MT;
      for (int k = 0; k < MT; k++) begin
         if (exp_card == 4'd0 && in_range(rv[k]) && rem[rv[k]] > 0) begin
            exp_card = rv[k];
            kd       = k;
         end
      end
      if (exp_card == 4'd0) begin
         start = in_range(rv[MT]) ? rv[MT] : 4'd1;
         for (int off = 0; off < 13; off++) begin
            r = 4'((int'(start) - 1 + off) % 13 + 1);
            if (exp_card == 4'd0 && rem[r] > 0) exp_card = r;
         end
      end

      req = rq;
      @(negedge clk);
      for (int k = 0; k <= kd; k++) begin
         check("draw_busy", busy, 1);
         check("draw_gnt", gnt, 0);
         rnd = rv[k];
         if (shuf && k == 0) shuffle = 1'b1;
         @(negedge clk);
         shuffle = 1'b0;
      end
      rem[exp_card]--;
      left--;
      check("deliver_left", cards_left, left);
      check("deliver_empty", deck_empty, (left == 0));
      check("deliver_gnt", gnt, 0);
      check("deliver_card", card, exp_card);
      @(negedge clk);
      check("gnt", gnt, N'(1) << w);
      check("card_valid", card_valid, 1);
      check("card", card, exp_card);
      check("idle_busy", busy, 0);
      got   = card;
      ptr_m = (w + 1) % N;
      req   = '0;
   endtask

   task automatic shuffle_idle();
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      check("shuf_busy", busy, 1);
      @(negedge clk);
      model_refill();
      check("shuf_left", cards_left, FULL);
      check("shuf_idle", busy, 0);
   endtask

   initial begin
      logic [3:0] got;
      rst = 1'b0; req = '0; shuffle = 1'b0; rnd = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_valid", card_valid, 0);
      check("rst_card", card, 0);
      check("rst_busy", busy, 0);
      check("rst_left", cards_left, FULL);
      check("rst_empty", deck_empty, 0);
      rst = 1'b1;
      model_refill();
      ptr_m = 0;

      // Single player deal: minimum latency, shoe drops to 51.
      do_deal(2'b01, 1'b0, 0, 1'b0, got);
      check("t1_range", in_range(got), 1);
      check("t1_left", cards_left, 51);

      // Both requesters held: grants alternate.
      repeat (4) do_deal(2'b11, 1'b0, 0, 1'b0, got);

      // Shuffle during DRAW: deal completes, then the shoe refills.
      do_deal(2'b10, 1'b0, 0, 1'b1, got);
      @(negedge clk);
      check("pend_shuf_busy", busy, 1);
      check("pend_shuf_gnt", gnt, 0);
      @(negedge clk);
      model_refill();
      check("pend_shuf_left", cards_left, FULL);
      check("pend_shuf_idle", busy, 0);

      // Exhausted rank 5 forces the fallback scan.
      repeat (4) do_deal(2'b01, 1'b1, 5, 1'b0, got);
      do_deal(2'b01, 1'b1, 5, 1'b0, got);
      check("fallback_6", got, 6);
      for (int r = 6; r <= 13; r++)
         while (rem[r] > 0) do_deal(2'b01, 1'b1, r, 1'b0, got);
      do_deal(2'b01, 1'b1, 5, 1'b0, got);
      check("fallback_wrap_1", got, 1);

      // Reset during DRAW with 40 cards left aborts the deal.
      shuffle_idle();
      repeat (12) do_deal(2'($urandom_range(1, 3)), 1'b0, 0, 1'b0, got);
      check("pre_rst_left", cards_left, 40);
      req = 2'b01;
      rnd = 4'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      model_refill();
      ptr_m = 0;
      check("midrst_left", cards_left, FULL);
      check("midrst_card", card, 0);
      check("midrst_busy", busy, 0);
      repeat (3) begin
         check("midrst_gnt", gnt, 0);
         @(negedge clk);
      end

      // Deal the whole shoe: each rank exactly 4*DECKS times.
      for (int r = 0; r < 16; r++) tally[r] = 0;
      repeat (FULL) begin
         do_deal(2'($urandom_range(1, 3)), 1'b0, 0, 1'b0, got);
         tally[got]++;
      end
      for (int r = 1; r <= 13; r++) check($sformatf("tally_%0d", r), tally[r], 4 * DECKS);
      check("empty_flag", deck_empty, 1);
      check("empty_left", cards_left, 0);
      req = 2'b11;
      repeat (6) begin
         @(negedge clk);
         check("empty_gnt", gnt, 0);
         check("empty_busy", busy, 0);
      end
      req = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
